reset_sequencer: RTL



---
 rtl/reset_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// Multi-channel reset sequencer. Active-low resets are released one at a time,
// in ascending channel order, once power-good and a debounced button have settled.
module reset_sequencer #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 32,
    parameter int STAGE_DLY    = 50000000,
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic                         OSC_50,
    input  logic                         RESET,
    input  logic                         BUTTON_N,
    input  logic                         PWR_GOOD,
    output logic [NUM_CH-1:0]            RESET_N_DY,
    output logic                         SEQ_DONE,
    output logic [$clog2(NUM_CH+1)-1:0]  STAGE
);

    localparam int STG_W   = $clog2(NUM_CH + 1);
    localparam int MAX_DLY = (STAGE_DLY > DEBOUNCE_CYC) ? STAGE_DLY : DEBOUNCE_CYC;

    localparam logic [CNT_W-1:0] STAGE_LAST  = CNT_W'(STAGE_DLY - 1);
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] DEB_MAX     = CNT_W'(DEBOUNCE_CYC);
    localparam logic [STG_W-1:0] STAGE_FINAL = STG_W'(NUM_CH - 1);

    generate
        if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
            $error("reset_sequencer: NUM_CH must be in 1..16");
        end
        if (STAGE_DLY < 1 || DEBOUNCE_CYC < 1) begin : g_bad_delay
            $error("reset_sequencer: STAGE_DLY and DEBOUNCE_CYC must be at least 1");
        end
        if (CNT_W < $clog2(MAX_DLY + 1)) begin : g_bad_cnt_w
            $error("reset_sequencer: CNT_W too narrow for STAGE_DLY/DEBOUNCE_CYC");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_WAIT,
        ST_RUN
    } state_t;

    state_t             state;
    state_t             state_next;

    logic               btn_meta;
    logic               btn_s;
    logic               pg_meta;
    logic               pg_s;
    logic [CNT_W-1:0]   deb_cnt;
    logic               press;
    logic               abort;

    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [NUM_CH-1:0]  rst_q;
    logic [NUM_CH-1:0]  rst_next;
    logic               done_q;
    logic               done_next;
    logic [STG_W-1:0]   stage_q;
    logic [STG_W-1:0]   stage_next;

    // Idle level of the synchronisers is "button up, power not good".
    always_ff @(posedge OSC_50) begin
        if (RESET) begin
            btn_meta <= 1'b1;
            btn_s    <= 1'b1;
            pg_meta  <= 1'b0;
            pg_s     <= 1'b0;
            deb_cnt  <= '0;
        end else begin
            btn_meta <= BUTTON_N;
            btn_s    <= btn_meta;
            pg_meta  <= PWR_GOOD;
            pg_s     <= pg_meta;
            if (btn_s) begin
                deb_cnt <= '0;
            end else if (deb_cnt != DEB_MAX) begin
                deb_cnt <= deb_cnt + CNT_W'(1);
            end
        end
    end

    assign press = !btn_s && (deb_cnt == DEB_LAST);
    assign abort = !pg_s || press;

    always_ff @(posedge OSC_50) begin
        if (RESET) begin
            state   <= ST_HOLD;
            cnt     <= '0;
            rst_q   <= '0;
            done_q  <= 1'b0;
            stage_q <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            rst_q   <= rst_next;
            done_q  <= done_next;
            stage_q <= stage_next;
        end
    end

    // Outputs are registered and the release vector only ever shifts in a 1,
    // so channels cannot come out of reset out of order.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        rst_next   = rst_q;
        done_next  = done_q;
        stage_next = stage_q;
        case (state)
            ST_HOLD: begin
                cnt_next   = '0;
                rst_next   = '0;
                done_next  = 1'b0;
                stage_next = '0;
                if (btn_s && pg_s && (deb_cnt == '0)) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    state_next = ST_HOLD;
                    cnt_next   = '0;
                    rst_next   = '0;
                    done_next  = 1'b0;
                    stage_next = '0;
                end else if (cnt == STAGE_LAST) begin
                    cnt_next   = '0;
                    rst_next   = (rst_q << 1) | NUM_CH'(1);
                    stage_next = stage_q + STG_W'(1);
                    if (stage_q == STAGE_FINAL) begin
                        state_next = ST_RUN;
                        done_next  = 1'b1;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ST_RUN: begin
                cnt_next = '0;
                if (abort) begin
                    state_next = ST_HOLD;
                    rst_next   = '0;
                    done_next  = 1'b0;
                    stage_next = '0;
                end
            end
            default: begin
                state_next = ST_HOLD;
                cnt_next   = '0;
                rst_next   = '0;
                done_next  = 1'b0;
                stage_next = '0;
            end
        endcase
    end

    always_comb begin
        RESET_N_DY = rst_q;
        SEQ_DONE   = done_q;
        STAGE      = stage_q;
    end

endmodule
